// File: rtl/mul5b_pkg.sv
// Shared widths and FSM state encoding for the 5x5 sequential shift-add multiplier.
package mul5b_pkg;

    localparam int MUL_N  = 5;
    localparam int MUL_PW = 2 * MUL_N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul5b_step.sv
// One shift-add step: acc + (y_bit ? x << shift : 0), full product width.
module mul5b_step #(
    parameter int N = 5
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   x,
    input  logic           y_bit,
    input  logic [2:0]     shift,
    output logic [2*N-1:0] sum
);

    localparam int PW = 2 * N;

    logic [PW-1:0] term;

    always_comb begin
        term = '0;
        if (y_bit) begin
            term = PW'(x) << shift;
        end
        sum = acc + term;
    end

endmodule

// File: rtl/mul5b_seq.sv
// Sequential unsigned multiplier: one partial product per RUN cycle, result
// registered on the final step and announced with a one-cycle done pulse.
module mul5b_seq
    import mul5b_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] out
);

    localparam int PW = 2 * N;

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [PW-1:0] out_q, out_d;
    logic [PW-1:0] step_sum;
    logic          last_step;

    mul5b_step #(.N(N)) u_step (
        .acc   (acc_q),
        .x     (x_q),
        .y_bit (y_q[cnt_q]),
        .shift (cnt_q),
        .sum   (step_sum)
    );

    assign last_step = (cnt_q == 3'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        out  = out_q;
    end

    // Operands are captured only on acceptance, so start/x/y are ignored during RUN.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_d = out_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d   = x;
                    y_d   = y;
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                acc_d = step_sum;
                cnt_d = cnt_q + 3'd1;
                if (last_step) begin
                    out_d = step_sum;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

endmodule

// File: doc/mul5b_seq.md
MUL5B_SEQ -- requirements
Module: mul5b_seq

Interface
REQ-001 Parameter N, default 5: operand width; product width is 2N; only N=5 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to multiply x by y; sampled on rising edge.
REQ-005 x  input  5  multiplicand (unsigned), sampled only when start is accepted.
REQ-006 y  input  5  multiplier (unsigned), sampled only when start is accepted.
REQ-007 busy  output  1  high while an operation is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse; out holds a new valid product while high.
REQ-009 out  output  10  registered unsigned product x*y.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 IDLE: start=1 SHALL latch x, y into internal registers, clear the 10-bit accumulator and the 3-bit step counter, and enter RUN.
REQ-012 RUN: at each edge with step count i (0..4), the accumulator SHALL add (x_reg << i) if y_reg[i]=1, otherwise add 0; the counter SHALL then increment.
REQ-013 RUN: the edge at i=4 SHALL load out with the final accumulator value (including the i=4 term) and enter DONE.
REQ-014 Latency: start sampled at edge E0 SHALL produce done=1 during the cycle after edge E5 (five RUN cycles), exactly one cycle wide.
REQ-015 DONE: done=1 and busy=0; the next edge SHALL enter IDLE, or SHALL enter RUN with fresh operands if start=1 (back-to-back accepted).
REQ-016 start SHALL be ignored while in RUN; x and y changes during RUN SHALL NOT affect the result.
REQ-017 out SHALL change only on the RUN-to-DONE edge and SHALL hold its value otherwise, including through IDLE and later RUN phases.
REQ-018 Arithmetic SHALL be unsigned, 10 bits wide; maximum 31*31=961 never overflows, and no carry is discarded.
REQ-019 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE.

Reset
REQ-020 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, out=0, accumulator=0, counter=0, regardless of start.
REQ-021 Reset asserted in RUN or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-022 rst has priority over start in the same cycle.

Structure
REQ-023 A shared package SHALL hold N, product width 2N, and the FSM state encoding (IDLE, RUN, DONE).
REQ-024 One sub-module, mul5b_step, SHALL be instantiated: combinational accumulator + (y bit ? x << i : 0), 10-bit result.
REQ-025 All other logic (FSM, counter, operand/accumulator/out registers) SHALL reside in mul5b_seq.

Verification
REQ-026 Reset, then x=31, y=31, start for 1 cycle -> busy for 5 cycles, done one cycle later, out=961.
REQ-027 x=21, y=10 -> out=210; x=0, y=31 -> out=0; x=31, y=0 -> out=0; done pulse each time.
REQ-028 Back-to-back: start held high through DONE with x=7, y=9 then x=3, y=5 -> out=63 then out=15, with done pulses 6 cycles apart.
REQ-029 Start at x=12, y=12; in RUN change x, y and pulse start -> result out=144; the extra start is ignored.
REQ-030 Start at x=5, y=6; assert rst in the 3rd RUN cycle -> no done pulse, out=0, busy=0 the cycle after reset.
REQ-031 Exhaustive: all 1024 (x, y) pairs compared against the unsigned product, with done asserted exactly once per operation.
